// File: rtl/conv_pkg.sv
// Shared definitions for the convolution launcher: FSM state encoding,
// X/Y and Z memory address widths, and the default core handshake timeout.
package conv_pkg;

    localparam int XY_AW       = 5;
    localparam int Z_AW        = 6;
    localparam int TMO_DEFAULT = 1023;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_Y,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RD_ADDR,
        S_RD_DATA,
        S_STREAM
    } state_t;

endpackage

// File: rtl/conv_launcher.sv
// Job launcher for a convolution core: loads X/Y memories, starts the core,
// then streams Z out. Define CONV_LAUNCHER_TIMEOUT_EN to enable the core timeout.
module conv_launcher
    import conv_pkg::*;
#(
    parameter int DW  = 8,
    parameter int ZW  = 16,
    parameter int TMO = TMO_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [XY_AW-1:0] cfg_nx,
    input  logic [XY_AW-1:0] cfg_ny,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             memx_we,
    output logic             memy_we,
    output logic [XY_AW-1:0] mem_addr,
    output logic [DW-1:0]    mem_wdata,
    output logic             core_start,
    input  logic             core_busy,
    input  logic             core_done,
    output logic [Z_AW-1:0]  memz_addr,
    input  logic [ZW-1:0]    memz_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ZW-1:0]    m_data,
    output logic             m_last,
    output logic             err_tmo
);

    if (TMO < 1) begin : g_bad_tmo
        $error("conv_launcher: TMO must be at least 1");
    end

    state_t           r_state;
    state_t           w_next;
    logic [XY_AW-1:0] r_nx;
    logic [XY_AW-1:0] r_ny;
    logic [Z_AW-1:0]  r_k;
    logic [ZW-1:0]    r_m_data;
    logic [Z_AW-1:0]  w_len;
    logic             w_z_last;
    logic             w_in_wait;
    logic             w_tmo_hit;

    // Lengths are stored minus one, so L = nx + ny + 1 fits in 6 bits (max 63).
    assign w_len     = {1'b0, r_nx} + {1'b0, r_ny} + 6'd1;
    assign w_z_last  = (r_k == w_len - 6'd1);
    assign w_in_wait = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    assign m_data    = r_m_data;

`ifdef CONV_LAUNCHER_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] r_tmo_cnt;

    assign w_tmo_hit = w_in_wait && (r_tmo_cnt == TW'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_in_wait) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; a valid source holds its data stable until that edge.
    always_comb begin
        w_next     = r_state;
        cfg_ready  = 1'b0;
        s_ready    = 1'b0;
        memx_we    = 1'b0;
        memy_we    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        core_start = 1'b0;
        memz_addr  = '0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        err_tmo    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) w_next = S_LOAD_X;
            end
            S_LOAD_X: begin
                s_ready   = 1'b1;
                memx_we   = s_valid;
                mem_addr  = r_k[XY_AW-1:0];
                mem_wdata = s_data;
                if (s_valid && (r_k[XY_AW-1:0] == r_nx)) w_next = S_LOAD_Y;
            end
            S_LOAD_Y: begin
                s_ready   = 1'b1;
                memy_we   = s_valid;
                mem_addr  = r_k[XY_AW-1:0];
                mem_wdata = s_data;
                if (s_valid && (r_k[XY_AW-1:0] == r_ny)) w_next = S_START;
            end
            S_START: begin
                core_start = 1'b1;
                w_next     = S_WAIT_BUSY;
            end
            // An idle core already shows done=1, so only busy can advance here.
            S_WAIT_BUSY: begin
                if (core_busy) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (core_done && !core_busy) w_next = S_RD_ADDR;
            end
            S_RD_ADDR: begin
                memz_addr = r_k;
                w_next    = S_RD_DATA;
            end
            S_RD_DATA: begin
                memz_addr = r_k;
                w_next    = S_STREAM;
            end
            S_STREAM: begin
                m_valid = 1'b1;
                m_last  = w_z_last;
                if (m_ready) w_next = w_z_last ? S_IDLE : S_RD_ADDR;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_tmo_hit) begin
            err_tmo = 1'b1;
            w_next  = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_nx     <= '0;
            r_ny     <= '0;
            r_m_data <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_k <= '0;
                    if (cfg_valid) begin
                        r_nx <= cfg_nx;
                        r_ny <= cfg_ny;
                    end
                end
                S_LOAD_X: begin
                    if (s_valid) r_k <= (r_k[XY_AW-1:0] == r_nx) ? '0 : r_k + 6'd1;
                end
                S_LOAD_Y: begin
                    if (s_valid) r_k <= r_k + 6'd1;
                end
                S_WAIT_DONE: r_k <= '0;
                S_RD_DATA:   r_m_data <= memz_rdata;
                S_STREAM: begin
                    if (m_ready && !w_z_last) r_k <= r_k + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/conv_launcher.md
CONV_LAUNCHER -- requirements
Module: conv_launcher

Interface
REQ-001 Parameter DW, default 8, input sample width.
REQ-002 Parameter ZW, default 16, result sample width.
REQ-003 Parameter TMO, default 1023, core handshake timeout in cycles.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cfg_valid/cfg_ready  in/out  1/1  job handshake; cfg_ready = 1 only in IDLE.
REQ-007 cfg_nx, cfg_ny  in  5/5  X and Y length minus 1 (0 means 1 sample, 31 means 32).
REQ-008 s_valid/s_ready/s_data  in/out/in  1/1/DW  input samples: X first, then Y.
REQ-009 memx_we, memy_we, mem_addr, mem_wdata  out  1/1/5/DW  core X/Y memory write port.
REQ-010 core_start  out  1  one-cycle start pulse to the convolution core.
REQ-011 core_busy, core_done  in  1/1  core status; core idles with done=1, busy=0.
REQ-012 memz_addr  out  6; memz_rdata  in  ZW  Z read port, 1-cycle read latency.
REQ-013 m_valid/m_ready/m_data/m_last  out/in/out/out  1/1/ZW/1  result stream.
REQ-014 err_tmo  out  1  one-cycle pulse on handshake timeout.

Function
REQ-015 States: IDLE, LOAD_X, LOAD_Y, START, WAIT_BUSY, WAIT_DONE, RD_ADDR, RD_DATA, STREAM.
REQ-016 IDLE: on cfg_valid, latch nx, ny, clear index k, go LOAD_X.
REQ-017 LOAD_X/LOAD_Y: s_ready=1; each s_valid&s_ready writes s_data at mem_addr=k with memx_we (or memy_we) high that same cycle.
REQ-018 LOAD_X after write at k=nx goes LOAD_Y with k=0; LOAD_Y after write at k=ny goes START.
REQ-019 START: core_start=1 for exactly one cycle, then WAIT_BUSY.
REQ-020 WAIT_BUSY: ignore core_done; on core_busy=1 go WAIT_DONE (stale done=1 from idle core never ends a job).
REQ-021 WAIT_DONE: on core_done=1 and core_busy=0 clear k, go RD_ADDR.
REQ-022 Result length L = nx+ny+1 samples (1..63), 6-bit arithmetic, no overflow.
REQ-023 RD_ADDR drives memz_addr=k; RD_DATA captures memz_rdata into m_data, sets m_valid; STREAM holds m_valid/m_data stable until m_ready.
REQ-024 m_last=1 with the sample k=L-1; after its acceptance go IDLE, else k+1 and RD_ADDR.
REQ-025 s_ready=0 and memx_we/memy_we=0 outside LOAD states; cfg_valid outside IDLE ignored.
REQ-026 s_valid deasserted mid-load: wait, no write, k holds.

Reset
REQ-027 Reset asserted any time: state IDLE, k=0, latched lengths 0, all outputs 0 except cfg_ready=1; a job in progress is abandoned without core_start.
REQ-028 First job after reset release behaves identically to any later job.

Configuration
REQ-029 CONV_LAUNCHER_TIMEOUT_EN defined: counter counts cycles in WAIT_BUSY+WAIT_DONE; on reaching TMO pulse err_tmo and return IDLE.
REQ-030 CONV_LAUNCHER_TIMEOUT_EN undefined: no counter, err_tmo tied 0, waits indefinitely.

Structure
REQ-031 Shared package conv_pkg holds the state enum, address widths (5 for X/Y, 6 for Z) and TMO default.
REQ-032 No sub-modules; single FSM plus index and timeout counters.

Verification
REQ-033 nx=2, ny=1, X=1,2,3, Y=4,5; model core -> mem writes X[0..2], Y[0..1], one core_start, stream 4,13,22,15, m_last on the 4th.
REQ-034 nx=0, ny=0 -> one X write, one Y write, L=1, single beat with m_last=1.
REQ-035 core holds done=1 for 5 cycles after core_start before busy -> no early readout; readout only after busy 1->0 with done=1.
REQ-036 m_ready low 10 cycles on beat 2 of nx=31, ny=31 -> m_data stable, 63 beats, last addr 62.
REQ-037 Timeout enabled, TMO=20, core never busy -> err_tmo pulse at cycle 20 in wait, cfg_ready=1 next cycle.
REQ-038 rst_n low during LOAD_Y -> outputs zero, cfg_ready=1; new job nx=1, ny=1 completes correctly.
